// File: rtl/lighthouse_pkg.sv
// Shared definitions for lighthouse_emitter: register map, FSM state
// encoding, sync-length helper and the fill word for unmapped reads.
package lighthouse_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_SWEEP0 = 6'd1;
    localparam logic [5:0] ADDR_SWEEP1 = 6'd2;
    localparam logic [5:0] ADDR_OOTX   = 6'd3;
    localparam logic [5:0] ADDR_STATUS = 6'd4;

    localparam logic [31:0] FILL_WORD = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_GAP,
        ST_SWEEP,
        ST_TAIL
    } state_t;

    // Sync pulse length in us for code = {skip, data, axis}.
    function automatic logic [15:0] sync_len(input logic [2:0] code,
                                             input int base_us = 63,
                                             input int step_us = 10);
        return 16'(base_us + step_us * int'(code));
    endfunction

endpackage

// File: rtl/lighthouse_emitter_if.sv
// Avalon-MM slave bus bundle for lighthouse_emitter.
interface lighthouse_emitter_if;
    logic [5:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lighthouse_emitter_us_tick_gen.sv
// us_tick_gen: CLK_DIV prescaler, one-cycle tick every CLK_DIV clocks.
module us_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);
    logic [9:0] cnt_q, cnt_d;

    // Down-counter; terminal count at zero produces the tick and reloads.
    always_comb begin
        tick  = (cnt_q == 10'd0);
        cnt_d = tick ? 10'(CLK_DIV - 1) : cnt_q - 10'd1;
    end

    // Prescaler register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter: synthesises a lighthouse optical sensor waveform
// (coded sync flash then sweep hit, axis alternating per frame).
// Optional feature macro: LIGHTHOUSE_OOTX_EN (data bit from an OOTX word).
//
// state | meaning
// IDLE  | output low, waiting for enable on a tick
// SYNC  | output high for sync_len(code) us
// GAP   | output low until us_cnt reaches the sweep time
// SWEEP | output high for SWEEP_WIDTH_US us
// TAIL  | output low until the last us of the frame
module lighthouse_emitter
    import lighthouse_pkg::*;
#(
    parameter int CLK_DIV        = 50,
    parameter int FRAME_US       = 8333,
    parameter int SYNC_BASE_US   = 63,
    parameter int SYNC_STEP_US   = 10,
    parameter int SWEEP_WIDTH_US = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    lighthouse_emitter_if.slave  bus,
    output logic                 sensor_signal_o,
    output logic                 frame_start,
    output logic                 axis_o
);
    logic        tick;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [13:0] sweep0_q, sweep0_d, sweep1_q, sweep1_d;
    state_t      state_q, state_d;
    logic [15:0] us_cnt_q, us_cnt_d, seg_cnt_q, seg_cnt_d;
    logic [15:0] sync_len_q, sync_len_d, frame_cnt_q, frame_cnt_d;
    logic [13:0] sweep_sh_q, sweep_sh_d;
    logic        axis_q, axis_d, sensor_q, sensor_d, frame_start_q, frame_start_d;
    logic        from_idle, axis_new, data_bit, start_frame, frame_end, suppress;
    logic [4:0]  bit_idx;
    logic [31:0] rdata;
    logic        unused_ok;
`ifdef LIGHTHOUSE_OOTX_EN
    logic [31:0] ootx_q, ootx_d, ootx_sh_q, ootx_sh_d, word;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic        reload;
`endif

    us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clock(clock), .reset_n(reset_n), .tick(tick));

    // Register file write decode; unmapped addresses are ignored.
    always_comb begin
        ctrl_d   = ctrl_q;
        sweep0_d = sweep0_q;
        sweep1_d = sweep1_q;
`ifdef LIGHTHOUSE_OOTX_EN
        ootx_d   = ootx_q;
`endif
        if (bus.write) begin
            case (bus.address)
                ADDR_CTRL:   ctrl_d   = bus.writedata[1:0];
                ADDR_SWEEP0: sweep0_d = bus.writedata[13:0];
                ADDR_SWEEP1: sweep1_d = bus.writedata[13:0];
`ifdef LIGHTHOUSE_OOTX_EN
                ADDR_OOTX:   ootx_d   = bus.writedata;
`endif
                default: ;
            endcase
        end
    end

    // Frame sequencer: all moves happen on the us tick; shadows latch at frame start.
    always_comb begin
        state_d       = state_q;
        us_cnt_d      = us_cnt_q;
        seg_cnt_d     = seg_cnt_q;
        sync_len_d    = sync_len_q;
        frame_cnt_d   = frame_cnt_q;
        sweep_sh_d    = sweep_sh_q;
        axis_d        = axis_q;
        frame_start_d = 1'b0;
        start_frame   = 1'b0;
        from_idle     = (state_q == ST_IDLE);
        axis_new      = from_idle ? 1'b0 : ~axis_q;
        frame_end     = (us_cnt_q == 16'(FRAME_US - 1));
        suppress      = ({2'b00, sweep_sh_q} < sync_len_q + 16'd1) ||
                        (({2'b00, sweep_sh_q} + 16'(SWEEP_WIDTH_US)) > 16'(FRAME_US));
`ifdef LIGHTHOUSE_OOTX_EN
        ootx_sh_d     = ootx_sh_q;
        bit_idx_d     = bit_idx_q;
        reload        = from_idle || (bit_idx_q == 5'd0);
        word          = reload ? ootx_q : ootx_sh_q;
        data_bit      = word[31];
`else
        data_bit      = 1'b0;
`endif
        if (tick) begin
            if (from_idle) begin
                start_frame = ctrl_q[0];
            end else if (frame_end) begin
                if (ctrl_q[0]) begin
                    start_frame = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    us_cnt_d = '0;
                end
            end else begin
                us_cnt_d = us_cnt_q + 16'd1;
                case (state_q)
                    ST_SYNC: begin
                        if (seg_cnt_q == 16'd0) state_d = ST_GAP;
                        else                    seg_cnt_d = seg_cnt_q - 16'd1;
                    end
                    ST_GAP: begin
                        if (suppress) begin
                            state_d = ST_TAIL;
                        end else if ({2'b00, sweep_sh_q} == us_cnt_q + 16'd1) begin
                            state_d   = ST_SWEEP;
                            seg_cnt_d = 16'(SWEEP_WIDTH_US - 1);
                        end
                    end
                    ST_SWEEP: begin
                        if (seg_cnt_q == 16'd0) state_d = ST_TAIL;
                        else                    seg_cnt_d = seg_cnt_q - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
        if (start_frame) begin
            state_d       = ST_SYNC;
            us_cnt_d      = '0;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            axis_d        = axis_new;
            sweep_sh_d    = axis_new ? sweep1_q : sweep0_q;
            sync_len_d    = sync_len({ctrl_q[1], data_bit, axis_new}, SYNC_BASE_US, SYNC_STEP_US);
            seg_cnt_d     = sync_len_d - 16'd1;
`ifdef LIGHTHOUSE_OOTX_EN
            ootx_sh_d     = {word[30:0], 1'b0};
            bit_idx_d     = reload ? 5'd31 : bit_idx_q - 5'd1;
`endif
        end
        sensor_d = (state_d == ST_SYNC) || (state_d == ST_SWEEP);
    end

    // Register file and sequencer state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            sweep0_q      <= '0;
            sweep1_q      <= '0;
            state_q       <= ST_IDLE;
            us_cnt_q      <= '0;
            seg_cnt_q     <= '0;
            sync_len_q    <= '0;
            frame_cnt_q   <= '0;
            sweep_sh_q    <= '0;
            axis_q        <= 1'b0;
            sensor_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            sweep0_q      <= sweep0_d;
            sweep1_q      <= sweep1_d;
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            seg_cnt_q     <= seg_cnt_d;
            sync_len_q    <= sync_len_d;
            frame_cnt_q   <= frame_cnt_d;
            sweep_sh_q    <= sweep_sh_d;
            axis_q        <= axis_d;
            sensor_q      <= sensor_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef LIGHTHOUSE_OOTX_EN
    // OOTX data word, its per-frame shift copy and the bit index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ootx_q    <= '0;
            ootx_sh_q <= '0;
            bit_idx_q <= '0;
        end else begin
            ootx_q    <= ootx_d;
            ootx_sh_q <= ootx_sh_d;
            bit_idx_q <= bit_idx_d;
        end
    end
    assign bit_idx = bit_idx_q;
`else
    assign bit_idx = 5'd0;
`endif

    // Combinational read mux, valid in the same cycle as the address.
    always_comb begin
        rdata = FILL_WORD;
        case (bus.address)
            ADDR_CTRL:   rdata = {30'd0, ctrl_q};
            ADDR_SWEEP0: rdata = {18'd0, sweep0_q};
            ADDR_SWEEP1: rdata = {18'd0, sweep1_q};
`ifdef LIGHTHOUSE_OOTX_EN
            ADDR_OOTX:   rdata = ootx_q;
`endif
            ADDR_STATUS: rdata = {9'd0, bit_idx, (state_q != ST_IDLE), axis_q, frame_cnt_q};
            default: ;
        endcase
    end

    assign bus.readdata    = rdata;
    assign bus.waitrequest = 1'b0;
    assign sensor_signal_o = sensor_q;
    assign frame_start     = frame_start_q;
    assign axis_o          = axis_q;
    // Read strobe is not needed by a combinational mux; high data bits only feed OOTX.
    assign unused_ok       = &{1'b0, bus.read, bus.writedata};
endmodule

// File: tb/tb_lighthouse_emitter.sv
// Directed bench for lighthouse_emitter with a pulse scoreboard.
module tb_lighthouse_emitter;
    localparam int CD = 2;
    localparam int FR = 1000;
`ifdef LIGHTHOUSE_OOTX_EN
    localparam bit OOTX_ON = 1'b1;
`else
    localparam bit OOTX_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic sensor, fs, axis;

    lighthouse_emitter_if bus();

    lighthouse_emitter #(.CLK_DIV(CD), .FRAME_US(FR)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .sensor_signal_o(sensor), .frame_start(fs), .axis_o(axis)
    );

    always #5 clock = ~clock;

    typedef struct { int start; int width; } pulse_t;
    pulse_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_pulse(input int start_us, input int width_us);
        pulse_t p;
        p.start = start_us * CD;
        p.width = width_us * CD;
        exp_q.push_back(p);
    endtask

    function automatic logic [31:0] st(input int cnt, input bit ax, input bit busy, input int idx);
        logic [31:0] r;
        r = '0;
        r[15:0] = cnt[15:0];
        r[16]   = ax;
        r[17]   = busy;
        if (OOTX_ON) r[22:18] = idx[4:0];
        return r;
    endfunction

    // Pulse monitor: start offset from frame_start and width, in clocks.
    int   cyc = 0, fs_cyc = 0, rise_cyc = 0;
    logic prev = 1'b0;
    always @(negedge clock) begin
        pulse_t e;
        if (!reset_n) begin
            prev = 1'b0;
        end else begin
            cyc++;
            if (fs === 1'b1) fs_cyc = cyc;
            if (sensor === 1'b1 && prev === 1'b0) rise_cyc = cyc;
            if (sensor === 1'b0 && prev === 1'b1) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin e.start = -1; e.width = -1; end
                check("pulse_start", rise_cyc - fs_cyc, e.start);
                check("pulse_width", cyc - rise_cyc, e.width);
            end
            prev = sensor;
        end
    end

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clock);
        bus.address = a;
        bus.read = 1'b1;
        #1 d = bus.readdata;
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.address = a;
        bus.writedata = d;
        bus.write = 1'b1;
        @(negedge clock);
        bus.write = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int n);
        n = 0;
        while (n < 3 * FR * CD) begin
            @(negedge clock);
            n++;
            if (fs === 1'b1) break;
        end
        check({tag, "_fs"}, {31'd0, fs}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        int k;
        k = 0;
        do begin
            rd(6'd4, d);
            k++;
        end while (d[17] && k < 3 * FR * CD);
        check({tag, "_idle"}, {31'd0, d[17]}, 32'd0);
        check({tag, "_queue"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        int sw_tab[5];
        bit hit_tab[5];
        sw_tab  = '{50, 63, 64, FR - 9, FR - 10};
        hit_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_sensor", {31'd0, sensor}, 32'd0);
        check("rst_fs", {31'd0, fs}, 32'd0);
        check("rst_axis", {31'd0, axis}, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle with enable clear.
        rd(6'd4, d); check("idle_status", d, 32'd0);
        rd(6'd9, d); check("unmapped_read", d, 32'hDEAD_BEEF);
        rd(6'd3, d); check("ootx_reset", d, OOTX_ON ? 32'd0 : 32'hDEAD_BEEF);
        repeat (2000 * CD) @(negedge clock);
        check("idle_sensor", {31'd0, sensor}, 32'd0);
        rd(6'd4, d); check("idle_status2", d, 32'd0);

        // Basic frames.
        wr(6'd1, 32'd400);
        wr(6'd2, 32'd600);
        rd(6'd1, d); check("sweep0_rb", d, 32'd400);
        for (int f = 0; f < 2; f++) begin
            expect_pulse(0, 63); expect_pulse(400, 10);
            expect_pulse(0, 73); expect_pulse(600, 10);
        end
        wr(6'd0, 32'd1);
        wait_fs("basic1", n);
        check("basic1_axis", {31'd0, axis}, 32'd0);
        rd(6'd4, d); check("basic1_status", d, st(1, 1'b0, 1'b1, 31));
        wait_fs("basic2", n);
        check("basic2_axis", {31'd0, axis}, 32'd1);
        wait_fs("basic3", n);
        check("frame_period", n, FR * CD);
        check("basic3_axis", {31'd0, axis}, 32'd0);
        rd(6'd4, d); check("basic3_status", d, st(3, 1'b0, 1'b1, 29));
        wait_fs("basic4", n);
        wr(6'd0, 32'd0);
        wait_idle("basic");
        rd(6'd4, d); check("basic_count", d & 32'h0002_FFFF, 32'd4);

        // Skip plus OOTX data bit.
        wr(6'd3, 32'h8000_0000);
        rd(6'd3, d); check("ootx_rb", d, OOTX_ON ? 32'h8000_0000 : 32'hDEAD_BEEF);
        expect_pulse(0, OOTX_ON ? 123 : 103); expect_pulse(400, 10);
        expect_pulse(0, 113); expect_pulse(600, 10);
        expect_pulse(0, 103); expect_pulse(400, 10);
        expect_pulse(0, 113); expect_pulse(600, 10);
        wr(6'd0, 32'd3);
        wait_fs("ootx1", n);
        check("ootx1_axis", {31'd0, axis}, 32'd0);
        rd(6'd4, d); check("ootx1_status", d, st(5, 1'b0, 1'b1, 31));
        wait_fs("ootx2", n);
        rd(6'd4, d); check("ootx2_status", d, st(6, 1'b1, 1'b1, 30));
        wait_fs("ootx3", n);
        wait_fs("ootx4", n);
        wr(6'd0, 32'd0);
        wait_idle("ootx");
        wr(6'd3, 32'd0);

        // Sweep suppression boundaries, one axis-0 frame each.
        for (int i = 0; i < 5; i++) begin
            wr(6'd1, sw_tab[i]);
            expect_pulse(0, 63);
            if (hit_tab[i]) expect_pulse(sw_tab[i], 10);
            wr(6'd0, 32'd1);
            wait_fs("supp", n);
            wr(6'd0, 32'd0);
            wait_idle("supp");
        end

        // Mid-frame SWEEP0 write only affects the next axis-0 frame.
        wr(6'd1, 32'd400);
        expect_pulse(0, 63); expect_pulse(400, 10);
        expect_pulse(0, 73); expect_pulse(600, 10);
        expect_pulse(0, 63); expect_pulse(500, 10);
        wr(6'd0, 32'd1);
        wait_fs("midA", n);
        repeat (200 * CD) @(negedge clock);
        wr(6'd1, 32'd500);
        wait_fs("midB", n);
        wait_fs("midC", n);
        wr(6'd0, 32'd0);
        wait_idle("mid");

        // Disable at us 300: frame completes at us FR, then idle.
        expect_pulse(0, 63); expect_pulse(500, 10);
        wr(6'd0, 32'd1);
        wait_fs("dis", n);
        repeat (300 * CD) @(negedge clock);
        wr(6'd0, 32'd0);
        repeat (FR * CD - 1 - (300 * CD + 2)) @(negedge clock);
        bus.address = 6'd4;
        #1 check("dis_busy_last", {31'd0, bus.readdata[17]}, 32'd1);
        @(negedge clock);
        #1 check("dis_busy_after", {31'd0, bus.readdata[17]}, 32'd0);
        check("dis_fs_after", {31'd0, fs}, 32'd0);
        check("dis_queue", exp_q.size(), 32'd0);

        // Reset in the middle of the sweep pulse.
        expect_pulse(0, 63);
        wr(6'd0, 32'd1);
        wait_fs("rst", n);
        repeat (500 * CD + 4) @(negedge clock);
        check("rst_in_sweep", {31'd0, sensor}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_drop", {31'd0, sensor}, 32'd0);
        check("rst_axis2", {31'd0, axis}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int a = 0; a < 5; a++) begin
            rd(6'(a), d);
            check("post_rst_reg", d, (a == 3 && !OOTX_ON) ? 32'hDEAD_BEEF : 32'd0);
        end
        check("post_rst_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
